// File: rtl/event_arbiter_pkg.sv
// Shared definitions for the event arbiter: class codes, event record layout
// and counter widths.
package event_arbiter_pkg;

  // A class code of zero means "no event this cycle" for that unit.
  localparam logic [1:0] CLASS_NONE = 2'b00;
  localparam int         CLASS_W    = 2;

  // Counter widths and the saturation ceiling for the drop counter.
  localparam int               DROP_W   = 8;
  localparam int               SPIKE_W  = 16;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  // An event record is {unit, class, timestamp}, with the timestamp in the LSBs.
  function automatic int rec_width(input int uid_w, input int ts_w);
    return uid_w + CLASS_W + ts_w;
  endfunction

  function automatic int class_lsb(input int ts_w);
    return ts_w;
  endfunction

  function automatic int uid_lsb(input int ts_w);
    return ts_w + CLASS_W;
  endfunction

endpackage

// File: rtl/event_arbiter_fifo.sv
// First-word-fall-through synchronous FIFO. The head entry is visible on
// pop_data whenever the FIFO is not empty; a push into a full FIFO is ignored.
module event_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int                PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0]    DEPTH_C = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  // Qualify push/pop against the current occupancy and advance pointers;
  // DEPTH is a power of two so the pointers wrap on their own.
  always_comb begin
    full     = (count_q == DEPTH_C);
    empty    = (count_q == '0);
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    pop_data = mem_q[rd_ptr_q];
    count    = count_q;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until pointed at, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/event_arbiter.sv
// Collects per-unit class events, holds one pending event per unit, grants
// them round-robin into a FWFT FIFO and presents them on a valid/ready port
// tagged with unit index, class code and frame timestamp.
module event_arbiter
  import event_arbiter_pkg::*;
#(
  parameter int  NUM_UNITS  = 4,
  parameter int  TS_WIDTH   = 16,
  parameter int  FIFO_DEPTH = 8,
  localparam int UID_W      = $clog2(NUM_UNITS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sample_valid,
  input  logic [NUM_UNITS-1:0]   spike_detection_array,
  input  logic [2*NUM_UNITS-1:0] event_out_array,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [UID_W-1:0]       evt_unit,
  output logic [1:0]             evt_class,
  output logic [TS_WIDTH-1:0]    evt_ts,
  output logic                   fifo_full,
  output logic [7:0]             drop_count,
  output logic [15:0]            spike_count
);

  localparam int               REC_W     = rec_width(UID_W, TS_WIDTH);
  localparam int               CLS_LSB   = class_lsb(TS_WIDTH);
  localparam int               UID_LSB   = uid_lsb(TS_WIDTH);
  localparam int               CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [UID_W-1:0] LAST_UNIT = UID_W'(NUM_UNITS - 1);

  logic [TS_WIDTH-1:0] ts_cnt_q, ts_cnt_d;
  logic [NUM_UNITS-1:0] pending_q, pending_d;
  logic [1:0]          class_q [NUM_UNITS];
  logic [1:0]          class_d [NUM_UNITS];
  logic [TS_WIDTH-1:0] ts_q    [NUM_UNITS];
  logic [TS_WIDTH-1:0] ts_d    [NUM_UNITS];
  logic [UID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [DROP_W-1:0]   drop_count_q, drop_count_d;
  logic [SPIKE_W-1:0]  spike_count_q, spike_count_d;

  logic                 grant_valid;
  logic [UID_W-1:0]     grant_idx;
  logic [UID_W-1:0]     cand_idx;
  logic [NUM_UNITS-1:0] grant_vec;
  logic [1:0]           unit_code;
  int                   drop_events;
  int                   drop_total;

  logic [REC_W-1:0] push_rec;
  logic [REC_W-1:0] head_rec;
  logic             fifo_pop;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  // Round-robin search over the pending flags starting at rr_ptr; nothing is
  // granted while the FIFO is full so the winner simply retries next cycle.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    grant_vec   = '0;
    cand_idx    = '0;
    if (!fifo_full) begin
      for (int k = 0; k < NUM_UNITS; k++) begin
        cand_idx = UID_W'((int'(rr_ptr_q) + k) % NUM_UNITS);
        if (!grant_valid && pending_q[cand_idx]) begin
          grant_valid = 1'b1;
          grant_idx   = cand_idx;
        end
      end
    end
    if (grant_valid) begin
      grant_vec[grant_idx] = 1'b1;
    end
    push_rec = {grant_idx, class_q[grant_idx], ts_q[grant_idx]};
    rr_ptr_d = rr_ptr_q;
    if (grant_valid) begin
      rr_ptr_d = (grant_idx == LAST_UNIT) ? '0 : grant_idx + 1'b1;
    end
  end

  // Capture new events into free (or just-granted) slots; an event landing on
  // a slot that is still occupied is lost and counted, saturating.
  always_comb begin
    pending_d   = pending_q & ~grant_vec;
    unit_code   = CLASS_NONE;
    drop_events = 0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      class_d[i] = class_q[i];
      ts_d[i]    = ts_q[i];
      unit_code  = event_out_array[2*i +: 2];
      if (unit_code != CLASS_NONE) begin
        if (!pending_q[i] || grant_vec[i]) begin
          pending_d[i] = 1'b1;
          class_d[i]   = unit_code;
          ts_d[i]      = ts_cnt_q;
        end else begin
          drop_events = drop_events + 1;
        end
      end
    end
    drop_total   = int'(drop_count_q) + drop_events;
    drop_count_d = (drop_total > int'(DROP_MAX)) ? DROP_MAX : DROP_W'(drop_total);
  end

  // Frame timestamp and spike activity counters, both free-running and wrapping.
  always_comb begin
    ts_cnt_d      = sample_valid ? ts_cnt_q + 1'b1 : ts_cnt_q;
    spike_count_d = (|spike_detection_array) ? spike_count_q + 1'b1 : spike_count_q;
  end

  // State registers; reset discards pending events and restarts all counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt_q      <= '0;
      pending_q     <= '0;
      rr_ptr_q      <= '0;
      drop_count_q  <= '0;
      spike_count_q <= '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
        class_q[i] <= '0;
        ts_q[i]    <= '0;
      end
    end else begin
      ts_cnt_q      <= ts_cnt_d;
      pending_q     <= pending_d;
      rr_ptr_q      <= rr_ptr_d;
      drop_count_q  <= drop_count_d;
      spike_count_q <= spike_count_d;
      class_q       <= class_d;
      ts_q          <= ts_d;
    end
  end

  event_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (grant_valid),
    .push_data (push_rec),
    .pop       (fifo_pop),
    .pop_data  (head_rec),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Output port: head fields are forced to zero while the FIFO is empty so the
  // port reads all-zero out of reset.
  always_comb begin
    evt_valid   = (fifo_count != '0);
    fifo_pop    = evt_valid & evt_ready;
    evt_unit    = fifo_empty ? '0 : head_rec[UID_LSB +: UID_W];
    evt_class   = fifo_empty ? '0 : head_rec[CLS_LSB +: CLASS_W];
    evt_ts      = fifo_empty ? '0 : head_rec[0 +: TS_WIDTH];
    drop_count  = drop_count_q;
    spike_count = spike_count_q;
  end

endmodule

// File: doc/event_arbiter.md
Name: event_arbiter

Overview:
Collects class events from the NUM_UNITS processing units of the spike-processing system and serialises them into one stream. Each event is tagged with unit index, class code and frame timestamp. Sits directly downstream of the processing system's spike_detection_array/event_out_array/sample_valid outputs. Uses per-unit pending flags, a round-robin grant, a small FIFO and a valid/ready output port.

Parameters:
NUM_UNITS, 4, number of processing units; must be at least 2.
TS_WIDTH, 16, width of the frame timestamp counter.
FIFO_DEPTH, 8, event FIFO entries; power of two, at least 2.
UID_W, $clog2(NUM_UNITS), unit index width (localparam).

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
sample_valid  in  1  one-cycle frame strobe from the processing system
spike_detection_array  in  NUM_UNITS  per-unit spike flag; informational, counted only
event_out_array  in  2*NUM_UNITS  per-unit class code, bits [2i+1:2i]; 2'b00 = no event
evt_valid  out  1  FIFO head holds an event
evt_ready  in  1  consumer accepts the head when evt_valid & evt_ready
evt_unit  out  UID_W  unit index of the head event
evt_class  out  2  class code of the head event (01, 10 or 11)
evt_ts  out  TS_WIDTH  frame timestamp of the head event
fifo_full  out  1  FIFO count == FIFO_DEPTH
drop_count  out  8  saturating count of lost events
spike_count  out  16  wrapping count of cycles with any spike_detection bit set

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: all outputs 0; pending flags, FIFO pointers and count, timestamp, rr_ptr all 0. An rst asserted mid-stream discards pending events and FIFO contents in that cycle.
- Timestamp: ts_cnt increments by 1 on every sample_valid and wraps at 2^TS_WIDTH.
- Capture, per unit i, every cycle: new_i = (event_out_array[2i+1:2i] != 0).
  - If new_i and the slot is free after this cycle's grant, i.e. (!pending_i | grant_i): set pending_i, latch class_i and ts_i = ts_cnt (pre-increment value).
  - If new_i and pending_i and !grant_i: event is dropped; drop_count += 1, saturating at 255.
  - Several drops in one cycle add the number of drops, still saturating.
- Arbitration: combinational round-robin over pending, searching from rr_ptr upward with wrap.
  - At most one grant per cycle, only when the FIFO is not full at the start of the cycle.
  - On grant to unit g: push {g, class_g, ts_g}, clear pending_g (unless it is re-captured the same cycle, see above), and set rr_ptr = g+1 mod NUM_UNITS.
  - No grant leaves rr_ptr unchanged.
- FIFO: first-word-fall-through; evt_valid = (count != 0); head fields are valid whenever evt_valid.
  - A pop occurs when evt_valid & evt_ready.
  - Push and pop in the same cycle leave count unchanged.
  - When full, no push, even if a pop occurs that cycle; the grant is simply retried the next cycle. Events are never dropped for FIFO space; only pending collisions drop.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency: event_out nonzero at edge t gives pending at t+1 and a push at edge t+2 if granted. The earliest evt_valid is 2 cycles after the input is sampled.
- Level-held event_out: a held nonzero code re-captures every cycle. The processing-unit contract makes event_out a one-cycle pulse.
- spike_count: increments on any cycle where |spike_detection_array; wraps at 2^16.

Decomposition:
- Shared package: CLASS_NONE = 2'b00, record field offsets and widths (UID_W, 2, TS_WIDTH), record width constant, drop counter width.
- One sub-module: event_fifo. It is a parameterised FWFT synchronous FIFO (WIDTH, DEPTH) with push, pop, full, empty and count.
- Arbiter and capture logic stay in event_arbiter.

Test Plan:
- Reset, then a single event_out_array=8'b00_00_10_00 (unit 1, class 10) at ts=5 -> evt_valid 2 cycles later with unit=1, class=2'b10, ts=5; drop_count stays 0.
- Units 0..3 all pulse class 01 in the same cycle with evt_ready=1 and rr_ptr=0 -> output order 0,1,2,3 on consecutive cycles. Then unit 3 and unit 0 together -> order 0,3 (rr_ptr=0 after the wrap from unit 3).
- Unit 2 pulses twice on consecutive cycles while the FIFO is full (evt_ready=0, 8 entries) -> second pulse dropped, drop_count=1. Release evt_ready -> the 8 old events, then exactly one unit-2 event.
- Hold evt_ready=0 for 300 colliding events -> drop_count saturates at 255; fifo_full=1; no push beyond 8.
- Push and pop in the same cycle with count=3 -> count stays 3; data order is preserved across pointer wrap after 20 events.
- Assert rst with 4 events queued and 2 pending -> next cycle evt_valid=0, drop_count=0, ts restarts at 0; a fresh event is reported with ts=0.
